dripper_scheduler: RTL and testbench
====================================

Name: dripper_scheduler

Overview:
- Multi-zone, time-aware successor of the single-zone combinational dripper.
- For each of N_ZONES zones it evaluates the drip condition: air humidity AND (low temperature OR water supply below mid).
- The condition is debounced, and each valve is driven through a per-zone state machine with minimum on-time, maximum on-time, cooldown and global lockout.
- A shared arbiter caps simultaneously open valves. The block sits inside the irrigation controller, in place of the per-zone combinational dripper.

Parameters:
N_ZONES, 4, number of independent drip zones (>=1)
DEBOUNCE, 3, consecutive ticks a raw demand must hold before it is accepted (>=1)
MIN_ON, 4, minimum ticks a valve stays open once opened, unless locked out (>=1, <=MAX_ON)
MAX_ON, 10, ticks after which an open valve is forced closed (timeout)
COOLDOWN, 5, ticks a zone rests closed after any close before it may request again (>=1)
MAX_OPEN, 2, maximum valves open at once (1..N_ZONES)

Ports:
clock  input  1  system clock; all state changes on rising edge
reset_n  input  1  synchronous, active-low reset
tick  input  1  one-clock time-base strobe; all timers count only on clocks where tick=1
air_humidity  input  N_ZONES  per-zone high-air-humidity flag
low_temperature  input  N_ZONES  per-zone cold-climate flag
mid_water_level  input  1  supply at or above middle level
critical_water_level  input  1  supply critical; forces lockout
sensor_fault  input  1  supply sensor inconsistency; forces lockout
dripper_valvule  output  N_ZONES  registered valve-open per zone
timeout  output  N_ZONES  one-clock pulse when the zone closes on MAX_ON expiry
lockout  output  1  registered (critical_water_level | sensor_fault), one-clock delay
open_count  output  clog2(N_ZONES+1)  registered number of zones in DRIP

Behaviour:
- Reset (reset_n=0 at a rising edge): all zones go to IDLE and all counters clear. Every output is 0: dripper_valvule, timeout, lockout, open_count.
- Raw demand per zone i: air_humidity[i] & (low_temperature[i] | ~mid_water_level). It is evaluated every clock.
- Debounce, per zone:
  - The stable flag (reset 0) is compared with raw demand on tick clocks.
  - When raw differs from stable, the counter increments; when they are equal, the counter clears.
  - When the counter reaches DEBOUNCE, stable flips and the counter clears.
  - On non-tick clocks the counter holds.
- lock_now = critical_water_level | sensor_fault. It is combinational, not debounced and acts in the same clock.
- Per-zone FSM states: IDLE, REQ, DRIP, REST. dripper_valvule[i] = (state==DRIP).
- IDLE:
  - stable & ~lock_now -> REQ.
- REQ:
  - lock_now | ~stable -> IDLE.
  - grant[i] -> DRIP, with the on-timer cleared.
- DRIP:
  - lock_now -> REST immediately; this overrides MIN_ON.
  - Otherwise, on a tick clock the on-timer increments. Then:
    - timer+1 == MAX_ON -> REST, with timeout[i] pulsed for that clock.
    - ~stable & timer+1 >= MIN_ON -> REST.
  - If both hold on the same tick, exit once and pulse timeout.
- REST:
  - The cooldown timer clears on entry and increments on ticks. When it reaches COOLDOWN -> IDLE.
  - lock_now does not affect REST.
- Arbiter:
  - At most one grant per clock, to the lowest-index zone in REQ.
  - A grant is issued only if the current count of zones in DRIP < MAX_OPEN.
  - A zone leaving DRIP frees its slot for a grant on the following clock, not the same one.
- Latency:
  - The stable flag rises at the edge processing the DEBOUNCE-th tick.
  - The zone enters REQ on the next edge.
  - dripper_valvule rises one edge later if granted, i.e. 2 clocks after stable.
  - Lockout closes a DRIP valve at the first edge where lock_now=1.
- Reset mid-DRIP closes the valve at that edge. There is no cooldown on exit from reset.
- Counter widths: clog2(max value+1). Counters saturate and never wrap.

Decomposition:
- Package dripper_pkg holds:
  - state encoding constants: IDLE=2'd0, REQ=2'd1, DRIP=2'd2, REST=2'd3;
  - a width-helper function for counter sizing.
- Sub-module dripper_zone (one instance per zone) contains the debounce, FSM and timers. It has ports: grant in, request/valve/timeout out.
- The top level contains the arbiter, open_count and the lockout register.

Test Plan (defaults: N_ZONES=4, DEBOUNCE=3, MIN_ON=4, MAX_ON=10, COOLDOWN=5, MAX_OPEN=2):
1. Zone0 air_humidity=1, low_temperature=1, tick every 4 clocks -> valve[0]=1 exactly 2 clocks after the 3rd tick. Raw drops after 1 tick and returns -> no open.
2. Zone1 opens, then demand is removed (debounced) after 2 on-ticks -> the valve stays open until on-tick 4, then closes. It cannot reopen for 5 ticks even with demand held.
3. Zone2 demand held continuously -> closes after 10 on-ticks with a single-clock timeout[2] pulse. It reopens after the 5-tick cooldown.
4. All 4 zones demand simultaneously -> zones 0 and 1 open on consecutive clocks, open_count=2, and zones 2 and 3 wait in REQ. Zone 0 times out -> zone 2 is granted the clock after zone 0 closes.
5. Zones 0 and 1 open; critical_water_level pulses high for 1 clock -> both valves close that edge, lockout=1 the next clock. The zones enter REST and no zone enters REQ while the lock is high.
6. mid_water_level=0, air_humidity[3]=1, low_temperature[3]=0 -> zone3 opens. Assert reset_n=0 for 1 clock mid-DRIP -> all outputs 0, and zone3 re-debounces from scratch.

Source files
------------

// File: rtl/dripper_pkg.sv
// Shared types and sizing helpers for the multi-zone drip scheduler.
package dripper_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DRIP = 2'd2,
    REST = 2'd3
  } zone_state_t;

  // Bits needed to hold values 0..max_val; never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dripper_zone.sv
// One drip zone: demand debounce, valve state machine, on-time and cooldown timers.
module dripper_zone
  import dripper_pkg::*;
#(
  parameter int DEBOUNCE = 3,
  parameter int MIN_ON   = 4,
  parameter int MAX_ON   = 10,
  parameter int COOLDOWN = 5
) (
  input  logic clock,
  input  logic reset_n,
  input  logic tick,
  input  logic raw,
  input  logic lock_now,
  input  logic grant,
  output logic request,
  output logic valve,
  output logic timeout
);

  localparam int DW = cnt_width(DEBOUNCE);
  localparam int OW = cnt_width(MAX_ON);
  localparam int RW = cnt_width(COOLDOWN);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE - 1);
  localparam logic [OW-1:0] MAX_ON_C = OW'(MAX_ON);
  localparam logic [OW-1:0] MIN_ON_C = OW'(MIN_ON);
  localparam logic [RW-1:0] COOL_C   = RW'(COOLDOWN);

  zone_state_t   state, state_next;
  logic          stable;
  logic [DW-1:0] deb_cnt;
  logic [OW-1:0] on_cnt, on_next, on_inc;
  logic [RW-1:0] rest_cnt, rest_next, rest_inc;
  logic          timeout_next;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      stable   <= 1'b0;
      deb_cnt  <= '0;
      on_cnt   <= '0;
      rest_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_next;
      on_cnt   <= on_next;
      rest_cnt <= rest_next;
      timeout  <= timeout_next;
      // Any tick that agrees with the accepted level restarts the debounce window.
      if (tick) begin
        if (raw != stable) begin
          if (deb_cnt == DEB_LAST) begin
            stable  <= ~stable;
            deb_cnt <= '0;
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end else begin
          deb_cnt <= '0;
        end
      end
    end
  end

  always_comb begin
    state_next   = state;
    on_next      = on_cnt;
    rest_next    = rest_cnt;
    timeout_next = 1'b0;
    on_inc       = (on_cnt >= MAX_ON_C) ? on_cnt : on_cnt + OW'(1);
    rest_inc     = (rest_cnt >= COOL_C) ? rest_cnt : rest_cnt + RW'(1);
    case (state)
      IDLE: begin
        if (stable && !lock_now) state_next = REQ;
      end
      REQ: begin
        if (lock_now || !stable) begin
          state_next = IDLE;
        end else if (grant) begin
          state_next = DRIP;
          on_next    = '0;
        end
      end
      DRIP: begin
        if (lock_now) begin
          state_next = REST;
          rest_next  = '0;
        end else if (tick) begin
          on_next = on_inc;
          // Timeout wins when it coincides with a demand-driven close.
          if (on_inc == MAX_ON_C) begin
            state_next   = REST;
            rest_next    = '0;
            timeout_next = 1'b1;
          end else if (!stable && on_inc >= MIN_ON_C) begin
            state_next = REST;
            rest_next  = '0;
          end
        end
      end
      REST: begin
        if (tick) begin
          rest_next = rest_inc;
          if (rest_inc == COOL_C) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign request = (state == REQ);
  assign valve   = (state == DRIP);

endmodule

// File: rtl/dripper_scheduler.sv
// Multi-zone drip scheduler: per-zone controllers, open-valve arbiter and supply lockout.
module dripper_scheduler
  import dripper_pkg::*;
#(
  parameter int N_ZONES  = 4,
  parameter int DEBOUNCE = 3,
  parameter int MIN_ON   = 4,
  parameter int MAX_ON   = 10,
  parameter int COOLDOWN = 5,
  parameter int MAX_OPEN = 2
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            tick,
  input  logic [N_ZONES-1:0]              air_humidity,
  input  logic [N_ZONES-1:0]              low_temperature,
  input  logic                            mid_water_level,
  input  logic                            critical_water_level,
  input  logic                            sensor_fault,
  output logic [N_ZONES-1:0]              dripper_valvule,
  output logic [N_ZONES-1:0]              timeout,
  output logic                            lockout,
  output logic [cnt_width(N_ZONES)-1:0]   open_count
);

  localparam int CW = cnt_width(N_ZONES);
  localparam logic [CW-1:0] MAX_OPEN_C = CW'(MAX_OPEN);

  logic               lock_now;
  logic [N_ZONES-1:0] raw;
  logic [N_ZONES-1:0] request;
  logic [N_ZONES-1:0] grant;
  logic [CW-1:0]      drip_count;
  logic               found;

  assign lock_now = critical_water_level | sensor_fault;
  assign raw      = air_humidity & (low_temperature | {N_ZONES{~mid_water_level}});

  genvar gi;
  generate
    for (gi = 0; gi < N_ZONES; gi++) begin : g_zone
      dripper_zone #(
        .DEBOUNCE (DEBOUNCE),
        .MIN_ON   (MIN_ON),
        .MAX_ON   (MAX_ON),
        .COOLDOWN (COOLDOWN)
      ) u_zone (
        .clock    (clock),
        .reset_n  (reset_n),
        .tick     (tick),
        .raw      (raw[gi]),
        .lock_now (lock_now),
        .grant    (grant[gi]),
        .request  (request[gi]),
        .valve    (dripper_valvule[gi]),
        .timeout  (timeout[gi])
      );
    end
  endgenerate

  // Counting current DRIP states means a slot freed at an edge is reusable only next clock.
  always_comb begin
    drip_count = '0;
    for (int i = 0; i < N_ZONES; i++) begin
      drip_count = drip_count + CW'(dripper_valvule[i]);
    end
  end

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N_ZONES; i++) begin
      if (request[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    if (lock_now || drip_count >= MAX_OPEN_C) grant = '0;
  end

  assign open_count = drip_count;

  always_ff @(posedge clock) begin
    if (!reset_n) lockout <= 1'b0;
    else          lockout <= lock_now;
  end

endmodule

// File: tb/tb_dripper_scheduler.sv
// Directed bench for dripper_scheduler with hand-computed expectations at default parameters.
module tb_dripper_scheduler;

  logic       clock;
  logic       reset_n;
  logic       tick;
  logic [3:0] air_humidity;
  logic [3:0] low_temperature;
  logic       mid_water_level;
  logic       critical_water_level;
  logic       sensor_fault;
  logic [3:0] dripper_valvule;
  logic [3:0] timeout;
  logic       lockout;
  logic [2:0] open_count;

  int checks   = 0;
  int failures = 0;

  dripper_scheduler dut (
    .clock                (clock),
    .reset_n              (reset_n),
    .tick                 (tick),
    .air_humidity         (air_humidity),
    .low_temperature      (low_temperature),
    .mid_water_level      (mid_water_level),
    .critical_water_level (critical_water_level),
    .sensor_fault         (sensor_fault),
    .dripper_valvule      (dripper_valvule),
    .timeout              (timeout),
    .lockout              (lockout),
    .open_count           (open_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock; t selects whether it is a tick clock. Returns 1 time unit after the edge.
  task automatic cyc(input logic t);
    tick = t;
    @(posedge clock);
    #1;
    tick = 1'b0;
  endtask

  task automatic clear_inputs();
    air_humidity         = 4'b0000;
    low_temperature      = 4'b0000;
    mid_water_level      = 1'b1;
    critical_water_level = 1'b0;
    sensor_fault         = 1'b0;
  endtask

  task automatic apply_reset(input string tag);
    reset_n = 1'b0;
    cyc(1'b0);
    chk({tag, "_valve"}, 32'(dripper_valvule), 32'h0);
    chk({tag, "_timeout"}, 32'(timeout), 32'h0);
    chk({tag, "_lockout"}, 32'(lockout), 32'h0);
    chk({tag, "_open_count"}, 32'(open_count), 32'h0);
    reset_n = 1'b1;
  endtask

  initial begin
    tick = 1'b0;
    reset_n = 1'b0;
    clear_inputs();
    cyc(1'b0);
    apply_reset("reset");

    // 1: zone0 glitch restarts debounce, then three consecutive ticks open it.
    air_humidity[0] = 1'b1; low_temperature[0] = 1'b1;
    cyc(1'b1); repeat (3) cyc(1'b0);
    low_temperature[0] = 1'b0;
    cyc(1'b1); repeat (3) cyc(1'b0);
    low_temperature[0] = 1'b1;
    cyc(1'b1); repeat (3) cyc(1'b0);
    cyc(1'b1); repeat (3) cyc(1'b0);
    chk("s1_glitch_no_open", 32'(dripper_valvule), 32'h0);
    cyc(1'b1);
    chk("s1_stable_edge", 32'(dripper_valvule), 32'h0);
    cyc(1'b0);
    chk("s1_req_edge", 32'(dripper_valvule), 32'h0);
    cyc(1'b0);
    chk("s1_open", 32'(dripper_valvule), 32'h1);
    chk("s1_open_count", 32'(open_count), 32'h1);

    // 2: zone1 demand drops early; MIN_ON holds it open until on-tick 4, then cooldown.
    clear_inputs(); apply_reset("s2_reset");
    air_humidity[1] = 1'b1; low_temperature[1] = 1'b1;
    repeat (3) cyc(1'b1);
    low_temperature[1] = 1'b0;
    cyc(1'b1);
    cyc(1'b1);
    chk("s2_open", 32'(dripper_valvule), 32'h2);
    repeat (3) cyc(1'b1);
    chk("s2_min_on_hold", 32'(dripper_valvule), 32'h2);
    cyc(1'b1);
    chk("s2_min_on_close", 32'(dripper_valvule), 32'h0);
    chk("s2_no_timeout", 32'(timeout), 32'h0);
    low_temperature[1] = 1'b1;
    repeat (4) cyc(1'b1);
    repeat (2) cyc(1'b0);
    chk("s2_cooldown_blocks", 32'(dripper_valvule), 32'h0);
    cyc(1'b1);
    cyc(1'b0);
    chk("s2_req_after_cool", 32'(dripper_valvule), 32'h0);
    cyc(1'b0);
    chk("s2_reopen", 32'(dripper_valvule), 32'h2);

    // 3: zone2 held demand times out after 10 on-ticks and reopens after cooldown.
    clear_inputs(); apply_reset("s3_reset");
    air_humidity[2] = 1'b1; low_temperature[2] = 1'b1;
    repeat (3) cyc(1'b1);
    repeat (2) cyc(1'b0);
    chk("s3_open", 32'(dripper_valvule), 32'h4);
    repeat (9) cyc(1'b1);
    chk("s3_before_timeout", 32'(dripper_valvule), 32'h4);
    chk("s3_no_early_timeout", 32'(timeout), 32'h0);
    cyc(1'b1);
    chk("s3_timeout_close", 32'(dripper_valvule), 32'h0);
    chk("s3_timeout_pulse", 32'(timeout), 32'h4);
    cyc(1'b0);
    chk("s3_timeout_single", 32'(timeout), 32'h0);
    repeat (4) cyc(1'b1);
    repeat (2) cyc(1'b0);
    chk("s3_cooldown_blocks", 32'(dripper_valvule), 32'h0);
    cyc(1'b1);
    repeat (2) cyc(1'b0);
    chk("s3_reopen", 32'(dripper_valvule), 32'h4);

    // 4: all zones demand; MAX_OPEN caps at two, freed slot reused the next clock.
    clear_inputs(); apply_reset("s4_reset");
    air_humidity = 4'hF; low_temperature = 4'hF;
    repeat (3) cyc(1'b1);
    repeat (2) cyc(1'b0);
    chk("s4_first_grant", 32'(dripper_valvule), 32'h1);
    cyc(1'b1);
    chk("s4_second_grant", 32'(dripper_valvule), 32'h3);
    chk("s4_open_count2", 32'(open_count), 32'h2);
    cyc(1'b0);
    chk("s4_cap_holds", 32'(dripper_valvule), 32'h3);
    repeat (8) cyc(1'b1);
    chk("s4_before_timeout", 32'(dripper_valvule), 32'h3);
    cyc(1'b1);
    chk("s4_z0_timeout_valve", 32'(dripper_valvule), 32'h2);
    chk("s4_z0_timeout_pulse", 32'(timeout), 32'h1);
    chk("s4_open_count1", 32'(open_count), 32'h1);
    cyc(1'b0);
    chk("s4_z2_granted", 32'(dripper_valvule), 32'h6);
    cyc(1'b1);
    chk("s4_z1_timeout_valve", 32'(dripper_valvule), 32'h4);
    chk("s4_z1_timeout_pulse", 32'(timeout), 32'h2);
    cyc(1'b0);
    chk("s4_z3_granted", 32'(dripper_valvule), 32'hC);
    chk("s4_open_count_end", 32'(open_count), 32'h2);

    // 5: lockout closes open valves at once and blocks new requests while held.
    clear_inputs(); apply_reset("s5_reset");
    air_humidity = 4'b0011; low_temperature = 4'b0011;
    repeat (3) cyc(1'b1);
    repeat (3) cyc(1'b0);
    chk("s5_both_open", 32'(dripper_valvule), 32'h3);
    critical_water_level = 1'b1;
    cyc(1'b0);
    chk("s5_lock_close", 32'(dripper_valvule), 32'h0);
    chk("s5_lockout_set", 32'(lockout), 32'h1);
    chk("s5_lock_open_count", 32'(open_count), 32'h0);
    critical_water_level = 1'b0;
    cyc(1'b0);
    chk("s5_lockout_clear", 32'(lockout), 32'h0);
    sensor_fault = 1'b1;
    repeat (5) cyc(1'b1);
    repeat (3) cyc(1'b0);
    chk("s5_held_lock_no_open", 32'(dripper_valvule), 32'h0);
    chk("s5_fault_lockout", 32'(lockout), 32'h1);
    sensor_fault = 1'b0;
    cyc(1'b0);
    chk("s5_release_lockout", 32'(lockout), 32'h0);
    chk("s5_release_req", 32'(dripper_valvule), 32'h0);
    repeat (2) cyc(1'b0);
    chk("s5_reopen", 32'(dripper_valvule), 32'h3);

    // 6: low supply drives zone3; reset mid-DRIP closes it and restarts debounce.
    clear_inputs(); apply_reset("s6_reset");
    mid_water_level = 1'b0; air_humidity[3] = 1'b1;
    repeat (3) cyc(1'b1);
    repeat (2) cyc(1'b0);
    chk("s6_open", 32'(dripper_valvule), 32'h8);
    chk("s6_open_count", 32'(open_count), 32'h1);
    repeat (2) cyc(1'b1);
    apply_reset("s6_mid_drip_reset");
    repeat (2) cyc(1'b1);
    repeat (2) cyc(1'b0);
    chk("s6_redebounce", 32'(dripper_valvule), 32'h0);
    cyc(1'b1);
    cyc(1'b0);
    chk("s6_req", 32'(dripper_valvule), 32'h0);
    cyc(1'b0);
    chk("s6_reopen", 32'(dripper_valvule), 32'h8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
